// File: rtl/pipe_stage_skid_buffer.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_buffer
//
// Purpose:
//    Parametrised inter-stage pipeline register with a valid/ready handshake.
//    It has a main entry, which drives the output, and one skid entry. The
//    upstream ready comes only from registered state, so the downstream
//    out_ready and hold never reach in_ready combinationally. A hold input
//    stalls the output side. A flush input squashes every beat held here and
//    any beat offered in the same cycle. The low CTRL_W payload bits
//    (regwrite/memtoreg style controls) read as zero whenever no beat is
//    presented, so a squashed slot cannot act downstream.
//
// Ports:
//    clk        in   rising-edge clock
//    rst        in   synchronous active-high reset
//    in_valid   in   upstream beat present
//    in_ready   out  buffer can accept a beat this cycle
//    in_data    in   upstream payload [DATA_W-1:0]
//    hold       in   stall: no beat leaves, input side may still fill
//    flush      in   squash all held beats and the beat offered this cycle
//    out_valid  out  downstream beat present
//    out_ready  in   downstream accepts beat
//    out_data   out  payload, low CTRL_W bits forced to 0 when out_valid=0
//    occupancy  out  number of valid entries (0..2)
// ---------------------------------------------------------------------------
module pipe_stage_skid_buffer #(
   parameter int                DATA_W  = 38,
   parameter int                CTRL_W  = 2,
   parameter logic [DATA_W-1:0] RST_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              hold,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   // Ones in the control-bit positions. Shifting a one past the top bit gives
   // zero, and zero minus one gives all ones, so CTRL_W = DATA_W masks the
   // whole word and CTRL_W = 0 masks nothing.
   localparam logic [DATA_W-1:0] ONE       = {{(DATA_W-1){1'b0}}, 1'b1};
   localparam logic [DATA_W-1:0] CTRL_MASK = (ONE << CTRL_W) - ONE;

   logic              main_valid_q, main_valid_d;
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] main_data_q,  main_data_d;
   logic [DATA_W-1:0] skid_data_q,  skid_data_d;

   logic in_fire;
   logic out_fire;

   // Handshake qualifiers. in_ready looks only at the skid flag and reset,
   // so upstream timing stays isolated from the downstream side.
   always_comb begin
      in_ready  = !skid_valid_q && !rst;
      out_valid = main_valid_q;
      in_fire   = in_valid && in_ready && !flush;
      out_fire  = main_valid_q && out_ready && !hold;
   end

   // Next-state logic for the two entries. The skid only fills when main is
   // occupied and not draining, and it always refills main before any new
   // beat is accepted, which keeps the order strictly FIFO.
   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_data_d  = main_data_q;
      skid_data_d  = skid_data_q;

      if (flush) begin
         // Data words are left stale; only the valid flags matter.
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (out_fire) begin
         if (skid_valid_q) begin
            main_data_d  = skid_data_q;
            skid_valid_d = 1'b0;
         end else if (in_fire) begin
            main_data_d  = in_data;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (in_fire) begin
         if (!main_valid_q) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
         end else begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
         end
      end
   end

   // State registers. Reset wins over flush, hold and any handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_data_q  <= RST_VAL;
         skid_data_q  <= RST_VAL;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_data_q  <= main_data_d;
         skid_data_q  <= skid_data_d;
      end
   end

   // Output payload with control bits squashed while no beat is presented.
   always_comb begin
      out_data  = main_valid_q ? main_data_q : (main_data_q & ~CTRL_MASK);
      occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
   end

endmodule
